sipo_capture: RTL and testbench

- Downstream consumer of the d_ff stage: samples its serial q output and assembles WIDTH-bit words.
- Presents each completed word on a valid/ready output handshake.
- Flags overrun when serial bits arrive while a finished word is still unaccepted.
- Intended as the next stage after the flop in bench and datapath chains.

---
 rtl/sipo_pkg.sv | 15 +
 rtl/sipo_shift_reg.sv | 38 +++
 rtl/sipo_capture.sv | 174 +++++++++++++++++
 tb/tb_sipo_capture.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out capture stage.
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Counter must be able to hold every index of a frame of frame_len bits.
    function automatic int unsigned cnt_width(input int unsigned frame_len);
        return $clog2(frame_len + 1);
    endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// WIDTH-bit shift register with synchronous clear; clear and shift may coincide so
// that a frame's first bit lands in a freshly cleared register.
module sipo_shift_reg #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             clr,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        base = clr ? '0 : q;
        q_d  = base;
        if (shift_en) begin
            if (MSB_FIRST) begin
                q_d = {base[WIDTH-2:0], din};
            end else begin
                q_d = {din, base[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= q_d;
        end
    end

endmodule

// File: rtl/sipo_capture.sv
// Assembles serial bits into WIDTH-bit words with a valid/ready output and sticky overrun.
// Define SIPO_PARITY_CHK_EN to append an even-parity bit to each frame and report out_perr.
module sipo_capture
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_en,
    input  logic             start,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             clr_ovr
`ifdef SIPO_PARITY_CHK_EN
    ,
    output logic             out_perr
`endif
);

`ifdef SIPO_PARITY_CHK_EN
    localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = WIDTH;
`endif
    localparam int unsigned   CW       = cnt_width(FRAME_LEN);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] DATA_LEN = CW'(WIDTH);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovr_q, ovr_d;
    logic            first;
    logic            take;
    logic            done;
    logic            accept;
    logic            ovr_set;
    logic            sr_shift;
    logic            sr_clr;
    logic            bit_in;
    logic [WIDTH-1:0] sr_q;

    // Gate din so an undriven line while din_en=0 never reaches state.
    assign bit_in = din & din_en;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        first   = 1'b0;
        take    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        ovr_set = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    first = 1'b1;
                end
            end
            SHIFT: begin
                if (start) begin
                    first = 1'b1;
                end else if (din_en) begin
                    take = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        done    = 1'b1;
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    accept  = 1'b1;
                    state_d = IDLE;
                    first   = start;
                end else if (din_en) begin
                    ovr_set = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Frame start (or restart) clears the partial word; a same-cycle bit is bit 1.
        if (first) begin
            state_d = SHIFT;
            cnt_d   = din_en ? CW'(1) : '0;
        end

        sr_clr   = first;
        // The trailing parity bit, when present, is never shifted into the data word.
        sr_shift = din_en & (first | (take & (cnt_q < DATA_LEN)));

        // Set takes priority over clear.
        ovr_d = ovr_set ? 1'b1 : (clr_ovr ? 1'b0 : ovr_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

    sipo_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clk      (clk),
        .rst      (rst),
        .shift_en (sr_shift),
        .clr      (sr_clr),
        .din      (bit_in),
        .q        (sr_q)
    );

`ifdef SIPO_PARITY_CHK_EN
    logic par_q, par_d;
    logic perr_q, perr_d;

    always_comb begin
        par_d  = par_q;
        perr_d = perr_q;
        if (first) begin
            par_d = bit_in;
        end else if (take) begin
            par_d = par_q ^ bit_in;
        end
        if (done) begin
            perr_d = par_q ^ bit_in;
        end else if (accept) begin
            perr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            par_q  <= par_d;
            perr_q <= perr_d;
        end
    end

    assign out_perr = perr_q;
`endif

    assign out_data  = sr_q;
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q == SHIFT);
    assign overrun   = ovr_q;

    cnt_in_range: assert property (@(posedge clk) disable iff (rst) cnt_q <= LAST_IDX);
    data_frozen: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> $stable(out_data));

endmodule

// File: tb/tb_sipo_capture.sv
// Randomized and directed bench for sipo_capture; MSB-first and LSB-first instances share stimulus.
module tb_sipo_capture;

    localparam int W = 8;
`ifdef SIPO_PARITY_CHK_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         din, din_en, start, out_ready, clr_ovr;
    logic [W-1:0] data_m, data_l;
    logic         valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l;
`ifdef SIPO_PARITY_CHK_EN
    logic         perr_m, perr_l;
`endif

    always #5 clk = ~clk;

    sipo_capture #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_en    (din_en),
        .start     (start),
        .out_data  (data_m),
        .out_valid (valid_m),
        .out_ready (out_ready),
        .busy      (busy_m),
        .overrun   (ovr_m),
`ifdef SIPO_PARITY_CHK_EN
        .out_perr  (perr_m),
`endif
        .clr_ovr   (clr_ovr)
    );

    sipo_capture #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_en    (din_en),
        .start     (start),
        .out_data  (data_l),
        .out_valid (valid_l),
        .out_ready (out_ready),
        .busy      (busy_l),
        .overrun   (ovr_l),
`ifdef SIPO_PARITY_CHK_EN
        .out_perr  (perr_l),
`endif
        .clr_ovr   (clr_ovr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a frame is just the list of bits received since the last start.
    bit           m_in_frame, m_have, m_ovr, m_perr;
    bit           m_bits[$];
    logic [W-1:0] m_word_m, m_word_l;

    task automatic model_reset();
        m_in_frame = 0;
        m_have     = 0;
        m_ovr      = 0;
        m_perr     = 0;
        m_bits.delete();
    endtask

    task automatic model_complete();
        bit x;
        x        = 0;
        m_word_m = '0;
        m_word_l = '0;
        for (int i = 0; i < W; i++) begin
            m_word_m[W-1-i] = m_bits[i];
            m_word_l[i]     = m_bits[i];
        end
        for (int i = 0; i < FL; i++) x ^= m_bits[i];
        m_perr     = x;
        m_have     = 1;
        m_in_frame = 0;
    endtask

    task automatic model_step(input bit s, input bit en, input bit d, input bit rdy, input bit clr);
        bit set;
        set = 0;
        if (m_have && !rdy) begin
            if (en) set = 1;
        end else begin
            if (m_have) begin
                m_have = 0;
                m_perr = 0;
            end
            if (s) begin
                m_in_frame = 1;
                m_bits.delete();
                if (en) m_bits.push_back(d);
            end else if (m_in_frame && en) begin
                m_bits.push_back(d);
                if (m_bits.size() == FL) model_complete();
            end
        end
        m_ovr = set ? 1'b1 : (clr ? 1'b0 : m_ovr);
    endtask

    task automatic check_outputs();
        check("valid_msb", 32'(valid_m), 32'(m_have));
        check("valid_lsb", 32'(valid_l), 32'(m_have));
        check("busy_msb", 32'(busy_m), 32'(m_in_frame));
        check("busy_lsb", 32'(busy_l), 32'(m_in_frame));
        check("overrun_msb", 32'(ovr_m), 32'(m_ovr));
        check("overrun_lsb", 32'(ovr_l), 32'(m_ovr));
        if (m_have) begin
            check("data_msb", 32'(data_m), 32'(m_word_m));
            check("data_lsb", 32'(data_l), 32'(m_word_l));
        end
`ifdef SIPO_PARITY_CHK_EN
        check("perr_msb", 32'(perr_m), 32'(m_have & m_perr));
        check("perr_lsb", 32'(perr_l), 32'(m_have & m_perr));
`endif
    endtask

    task automatic cycle(input bit s, input bit en, input bit d, input bit rdy, input bit clr);
        start     = s;
        din_en    = en;
        din       = en ? d : 1'b0;
        out_ready = rdy;
        clr_ovr   = clr;
        @(posedge clk);
        model_step(s, en, d, rdy, clr);
        #1;
        check_outputs();
    endtask

    // Sends word MSB-first on the wire (first bit = word[W-1]) starting with a start pulse.
    task automatic send_frame(input logic [W-1:0] word, input bit par);
        cycle(1, 1, word[W-1], 0, 0);
        for (int i = W - 2; i >= 0; i--) cycle(0, 1, word[i], 0, 0);
`ifdef SIPO_PARITY_CHK_EN
        cycle(0, 1, par, 0, 0);
`else
        if (par) cycle(0, 0, 0, 0, 0);
`endif
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data_msb"}, 32'(data_m), 32'h0);
        check({tag, "_data_lsb"}, 32'(data_l), 32'h0);
        check({tag, "_valid"}, 32'(valid_m | valid_l), 32'h0);
        check({tag, "_busy"}, 32'(busy_m | busy_l), 32'h0);
        check({tag, "_overrun"}, 32'(ovr_m | ovr_l), 32'h0);
    endtask

    initial begin
        bit lo_ready;
        rst       = 1'b1;
        start     = 0;
        din_en    = 0;
        din       = 0;
        out_ready = 0;
        clr_ovr   = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Nominal frame.
        send_frame(8'hB2, 1'b0);
        check("nominal_msb", 32'(data_m), 32'hB2);
        check("nominal_lsb", 32'(data_l), 32'h4D);
        check("nominal_valid", 32'(valid_m), 32'h1);
`ifdef SIPO_PARITY_CHK_EN
        check("nominal_perr", 32'(perr_m), 32'h0);
`endif

        // Backpressure with one dropped bit.
        for (int i = 0; i < 5; i++) cycle(0, i == 2, 1, 0, 0);
        check("hold_data", 32'(data_m), 32'hB2);
        check("hold_overrun", 32'(ovr_m), 32'h1);
        cycle(0, 0, 0, 0, 1);
        check("clr_overrun", 32'(ovr_m), 32'h0);

        // Back-to-back: accept and start together.
        cycle(1, 1, 1, 1, 0);
        check("b2b_busy", 32'(busy_m), 32'h1);
        for (int i = W - 2; i >= 0; i--) cycle(0, 1, (8'hC3 >> i) & 1, 0, 0);
`ifdef SIPO_PARITY_CHK_EN
        cycle(0, 1, 0, 0, 0);
`endif
        check("b2b_data", 32'(data_m), 32'hC3);
        check("b2b_overrun", 32'(ovr_m), 32'h0);
        cycle(0, 0, 0, 1, 0);
        check("accept_valid", 32'(valid_m), 32'h0);

        // Restart mid-frame after 3 bits.
        cycle(1, 1, 0, 0, 0);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);
        send_frame(8'hB2, 1'b0);
        check("restart_data", 32'(data_m), 32'hB2);
        cycle(0, 0, 0, 1, 0);

`ifdef SIPO_PARITY_CHK_EN
        send_frame(8'hB2, 1'b1);
        check("parity_err", 32'(perr_m), 32'h1);
        cycle(0, 0, 0, 1, 0);
        check("parity_clr", 32'(perr_m), 32'h0);
`endif

        // Asynchronous reset in the middle of a frame.
        cycle(1, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        send_frame(8'h6E, 1'b1);
        check("post_rst_msb", 32'(data_m), 32'h6E);
        check("post_rst_lsb", 32'(data_l), 32'h76);
        cycle(0, 0, 0, 1, 0);

        // Randomized traffic with alternating consumer pressure.
        lo_ready = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 500 == 0) lo_ready = !lo_ready;
            cycle(($urandom % 14) == 0, ($urandom % 4) != 0, $urandom % 2,
                  lo_ready ? (($urandom % 5) == 0) : (($urandom % 3) != 0),
                  ($urandom % 20) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
